// File: rtl/clock_switch_sequencer.sv
// Clock-source switch sequencer for the core clocking block.
// Falls back to ext_clk, applies new divider selects, optionally waits for
// PLL lock and settles before handing the core over to the PLL, then issues
// a core reset request.
// Build option: define CLKSEQ_RESET_PULSE_EN to drive ext_reset high for
// RESET_CYCLES cycles in RESETP; left undefined, ext_reset stays 0.
module clock_switch_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned RESET_CYCLES  = 4
) (
  input  logic       ext_clk,
  input  logic       resetb,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_pll_en,
  input  logic [2:0] req_sel,
  input  logic [2:0] req_sel2,
  input  logic       pll_lock,
  input  logic       err_clr,
  output logic       ext_clk_sel,
  output logic [2:0] sel,
  output logic [2:0] sel2,
  output logic       ext_reset,
  output logic       busy,
  output logic       error
);

`ifdef CLKSEQ_RESET_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);
  localparam logic [15:0] LOCK_LD   = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] RESET_LD  = 16'(RESET_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    FALLBACK,
    APPLY,
    WAIT_LOCK,
    SETTLE,
    RESETP
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        cap_pll_en;
  logic [2:0]  cap_sel;
  logic [2:0]  cap_sel2;
  logic        lock_m;
  logic        lock_s;
  logic        cnt_last;
  logic [15:0] cnt_dec;

  // Down-counter helpers; the decrement saturates at zero.
  assign cnt_last = (cnt <= 16'd1);
  assign cnt_dec  = (cnt == '0) ? '0 : cnt - 16'd1;

  // Two-flop synchronizer for the asynchronous PLL lock indicator.
  always_ff @(posedge ext_clk or negedge resetb) begin
    if (!resetb) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Sequencer FSM with all outputs registered; ext_reset is only ever
  // written with PULSE_EN, so it stays 0 when the pulse option is off and
  // RESETP then collapses to a single cycle.
  always_ff @(posedge ext_clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_pll_en  <= 1'b0;
      cap_sel     <= '0;
      cap_sel2    <= '0;
      ext_clk_sel <= 1'b1;
      sel         <= '0;
      sel2        <= '0;
      ext_reset   <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b1;
      error       <= 1'b0;
    end else begin
      // Clear first so any error set below in the same cycle wins.
      if (err_clr) error <= 1'b0;
      case (state)
        IDLE: begin
          if (!ext_clk_sel && !lock_s) begin
            ext_clk_sel <= 1'b1;
            error       <= 1'b1;
          end
          if (req_valid) begin
            cap_pll_en  <= req_pll_en;
            cap_sel     <= req_sel;
            cap_sel2    <= req_sel2;
            ext_clk_sel <= 1'b1;
            cnt         <= SETTLE_LD;
            state       <= FALLBACK;
            busy        <= 1'b1;
            req_ready   <= 1'b0;
          end
        end
        FALLBACK: begin
          if (cnt_last) state <= APPLY;
          else          cnt   <= cnt_dec;
        end
        APPLY: begin
          sel  <= cap_sel;
          sel2 <= cap_sel2;
          if (cap_pll_en) begin
            state <= WAIT_LOCK;
            cnt   <= LOCK_LD;
          end else begin
            state     <= RESETP;
            cnt       <= RESET_LD;
            ext_reset <= PULSE_EN;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= SETTLE_LD;
          end else if (cnt_last) begin
            error     <= 1'b1;
            state     <= RESETP;
            cnt       <= RESET_LD;
            ext_reset <= PULSE_EN;
          end else begin
            cnt <= cnt_dec;
          end
        end
        SETTLE: begin
          if (cnt_last) begin
            if (lock_s) ext_clk_sel <= 1'b0;
            else        error       <= 1'b1;
            state     <= RESETP;
            cnt       <= RESET_LD;
            ext_reset <= PULSE_EN;
          end else begin
            cnt <= cnt_dec;
          end
        end
        RESETP: begin
          if (!PULSE_EN || cnt_last) begin
            ext_reset <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt_dec;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
